// File: rtl/adv_timer_evt_in_pkg.sv
// Shared types, constants and the event-qualify helper for the advanced-timer event input stage.
package adv_timer_evt_in_pkg;

    typedef enum logic [2:0] {
        MODE_ALWAYS = 3'd0,
        MODE_HIGH   = 3'd1,
        MODE_LOW    = 3'd2,
        MODE_RISE   = 3'd3,
        MODE_FALL   = 3'd4,
        MODE_BOTH   = 3'd5,
        MODE_NEVER  = 3'd6
    } evt_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } evt_in_state_e;

    localparam int EVT_SYNC_STAGES = 2;
    localparam int EVT_FILT_DEPTH  = 3;

    // Codes 6 and 7 never qualify.
    function automatic logic evt_qualify(input logic [2:0] mode, input logic level,
                                         input logic rise, input logic fall);
        logic q;
        q = 1'b0;
        case (mode)
            MODE_ALWAYS: q = 1'b1;
            MODE_HIGH:   q = level;
            MODE_LOW:    q = ~level;
            MODE_RISE:   q = rise;
            MODE_FALL:   q = fall;
            MODE_BOTH:   q = rise | fall;
            default:     q = 1'b0;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/adv_timer_evt_in_sync.sv
// Synchroniser, optional 3-sample glitch filter and registered edge detect for one selected input.
// Filter enabled by defining ADV_TIMER_EVT_IN_GLITCH_FILTER_EN.
module adv_timer_evt_in_sync
    import adv_timer_evt_in_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [EVT_SYNC_STAGES-1:0] sync_q;
    logic                       s2;
    logic                       lvl;

    assign s2 = sync_q[EVT_SYNC_STAGES-1];

`ifdef ADV_TIMER_EVT_IN_GLITCH_FILTER_EN
    logic [EVT_FILT_DEPTH-2:0] hist;
    logic                      filt_q;
    logic                      agree;

    // Filtered level follows s2 only once the current and previous samples all agree.
    assign agree = (&{hist, s2}) | ~(|{hist, s2});
    assign lvl   = agree ? s2 : filt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist   <= '0;
            filt_q <= 1'b0;
        end else begin
            hist   <= {hist[EVT_FILT_DEPTH-3:0], s2};
            filt_q <= lvl;
        end
    end
`else
    assign lvl = s2;
`endif

    // level doubles as the previous-value register for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[EVT_SYNC_STAGES-2:0], din};
            level  <= lvl;
            rise   <= lvl & ~level;
            fall   <= ~lvl & level;
        end
    end

endmodule

// File: rtl/adv_timer_evt_in_stage.sv
// Event front-end for one timer channel: input select, qualify, prescale, run/arm FSM.
// Optional glitch filter in the sync path via ADV_TIMER_EVT_IN_GLITCH_FILTER_EN.
module adv_timer_evt_in_stage
    import adv_timer_evt_in_pkg::*;
#(
    parameter  int N_EXTSIG    = 32,
    parameter  int PRESC_WIDTH = 8,
    localparam int SEL_WIDTH   = $clog2(N_EXTSIG)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cfg_start_i,
    input  logic                   cfg_stop_i,
    input  logic                   cfg_arm_i,
    input  logic                   cfg_update_i,
    input  logic [SEL_WIDTH-1:0]   cfg_sel_i,
    input  logic [2:0]             cfg_mode_i,
    input  logic [PRESC_WIDTH-1:0] cfg_presc_i,
    input  logic [N_EXTSIG-1:0]    signal_i,
    output logic                   evt_o,
    output logic                   active_o,
    output logic                   armed_o
);

    evt_in_state_e          state_q, state_d;
    logic [PRESC_WIDTH-1:0] cnt_q;
    logic [SEL_WIDTH-1:0]   sel_act, sel_pend;
    logic [2:0]             mode_act, mode_pend;
    logic [PRESC_WIDTH-1:0] presc_act, presc_pend;
    logic                   pend_vld;
    logic                   evt_q;
    logic                   din, level, rise, fall;
    logic                   in_run, qual, wrap;

    assign din = signal_i[sel_act];

    adv_timer_evt_in_sync u_sync (
        .clk   (clk_i),
        .rst   (rst_i),
        .din   (din),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    assign in_run = (state_q == RUN);
    assign qual   = evt_qualify(mode_act, level, rise, fall);
    // A start in RUN only clears the prescaler, so it also suppresses that cycle's event.
    assign wrap   = in_run && !cfg_stop_i && !cfg_start_i && qual && (cnt_q == presc_act);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_start_i && !cfg_stop_i) state_d = cfg_arm_i ? ARMED : RUN;
            ARMED:   if (cfg_stop_i) state_d = IDLE;
                     else if (rise)  state_d = RUN;
            RUN:     if (cfg_stop_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            evt_q      <= 1'b0;
            cnt_q      <= '0;
            sel_act    <= '0;
            mode_act   <= MODE_ALWAYS;
            presc_act  <= '0;
            sel_pend   <= '0;
            mode_pend  <= MODE_ALWAYS;
            presc_pend <= '0;
            pend_vld   <= 1'b0;
        end else begin
            evt_q <= wrap;

            if (!in_run || state_d != RUN || cfg_start_i) cnt_q <= '0;
            else if (qual)                                cnt_q <= wrap ? '0 : cnt_q + 1'b1;

            if (state_q == IDLE) begin
                if (cfg_update_i) begin
                    sel_act   <= cfg_sel_i;
                    mode_act  <= cfg_mode_i;
                    presc_act <= cfg_presc_i;
                end
                pend_vld <= 1'b0;
            end else if (cfg_stop_i) begin
                // Stop flushes any held update, a same-cycle update taking precedence.
                if (cfg_update_i) begin
                    sel_act   <= cfg_sel_i;
                    mode_act  <= cfg_mode_i;
                    presc_act <= cfg_presc_i;
                end else if (pend_vld) begin
                    sel_act   <= sel_pend;
                    mode_act  <= mode_pend;
                    presc_act <= presc_pend;
                end
                pend_vld <= 1'b0;
            end else begin
                if (wrap && pend_vld) begin
                    sel_act   <= sel_pend;
                    mode_act  <= mode_pend;
                    presc_act <= presc_pend;
                    pend_vld  <= 1'b0;
                end
                if (cfg_update_i) begin
                    sel_pend   <= cfg_sel_i;
                    mode_pend  <= cfg_mode_i;
                    presc_pend <= cfg_presc_i;
                    pend_vld   <= 1'b1;
                end
            end
        end
    end

    assign evt_o    = evt_q;
    assign active_o = (state_q == RUN);
    assign armed_o  = (state_q == ARMED);

endmodule
